// File: rtl/ctrl_seq_if.sv
// Handshake and control bundle between fetch/decode, ctrl_seq and the datapath.
// slave is the sequencer side; master is the surrounding pipeline.
interface ctrl_seq_if #(
    parameter int ALUW = 5
);
    logic            instr_valid;
    logic            instr_ready;
    logic [4:0]      opcode;
    logic [ALUW-1:0] alu_op_in;
    logic            alu_ovf;
    logic            md_ready;
    logic            md_exc;
    logic            ctrl_valid;
    logic            br;
    logic            jp;
    logic            jal;
    logic            dmwe;
    logic            rwe;
    logic            rdst;
    logic            aluinb;
    logic [1:0]      rwd;
    logic [ALUW-1:0] aluop;
    logic            md_start;
    logic            md_op;
    logic [4:0]      exc_rd;
    logic [2:0]      exc_code;
    logic            illegal;

    modport slave (
        input  instr_valid, opcode, alu_op_in, alu_ovf, md_ready, md_exc,
        output instr_ready, ctrl_valid, br, jp, jal, dmwe, rwe, rdst, aluinb,
               rwd, aluop, md_start, md_op, exc_rd, exc_code, illegal
    );

    modport master (
        output instr_valid, opcode, alu_op_in, alu_ovf, md_ready, md_exc,
        input  instr_ready, ctrl_valid, br, jp, jal, dmwe, rwe, rdst, aluinb,
               rwd, aluop, md_start, md_op, exc_rd, exc_code, illegal
    );
endinterface

// File: rtl/ctrl_seq.sv
// Multi-cycle instruction control sequencer: registered decode, mult/div stall
// with timeout, and an extra status-register write cycle on arithmetic exceptions.
module ctrl_seq #(
    parameter int ALUW       = 5,
    parameter int RSTAT      = 30,
    parameter int MD_TIMEOUT = 64,
    parameter int CNTW       = 7
) (
    input logic       clock,
    input logic       reset,
    ctrl_seq_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MD_WAIT, S_MD_DONE, S_EXC} state_t;

    typedef struct packed {
        logic            ctrl_valid;
        logic            br;
        logic            jp;
        logic            jal;
        logic            dmwe;
        logic            rwe;
        logic            rdst;
        logic            aluinb;
        logic [1:0]      rwd;
        logic [ALUW-1:0] aluop;
        logic            md_start;
        logic            md_op;
        logic [4:0]      exc_rd;
        logic [2:0]      exc_code;
        logic            illegal;
    } ctrl_t;

    localparam logic [ALUW-1:0] OP_ADD = ALUW'(0);
    localparam logic [ALUW-1:0] OP_SUB = ALUW'(1);
    localparam logic [ALUW-1:0] OP_MUL = ALUW'(6);
    localparam logic [ALUW-1:0] OP_DIV = ALUW'(7);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MD_TIMEOUT - 1);

    state_t          state_q, state_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [2:0]      pend_q, pend_d;
    logic            md_div_q, md_div_d;
    logic            md_exc_q, md_exc_d;

    ctrl_t      dec;
    logic       dec_md;
    logic       dec_div;
    logic [2:0] dec_exc;

    function automatic ctrl_t exc_ctrl(input logic [2:0] code);
        exc_ctrl            = '0;
        exc_ctrl.ctrl_valid = 1'b1;
        exc_ctrl.rwe        = 1'b1;
        exc_ctrl.rwd        = 2'b11;
        exc_ctrl.exc_rd     = 5'(RSTAT);
        exc_ctrl.exc_code   = code;
    endfunction

    // dec_exc is the exception code to raise if EXEC later sees alu_ovf
    always_comb begin
        dec            = '0;
        dec.ctrl_valid = 1'b1;
        dec_md         = 1'b0;
        dec_div        = 1'b0;
        dec_exc        = 3'd0;
        case (bus.opcode)
            5'b00000: begin
                if (bus.alu_op_in == OP_MUL || bus.alu_op_in == OP_DIV) begin
                    dec_md  = 1'b1;
                    dec_div = (bus.alu_op_in == OP_DIV);
                end else begin
                    dec.rwe   = 1'b1;
                    dec.rdst  = 1'b1;
                    dec.aluop = bus.alu_op_in;
                    if (bus.alu_op_in == OP_ADD)      dec_exc = 3'd1;
                    else if (bus.alu_op_in == OP_SUB) dec_exc = 3'd3;
                end
            end
            5'b00101: begin
                dec.rwe    = 1'b1;
                dec.aluinb = 1'b1;
                dec_exc    = 3'd2;
            end
            5'b00111: begin
                dec.dmwe   = 1'b1;
                dec.aluinb = 1'b1;
            end
            5'b01000: begin
                dec.rwe    = 1'b1;
                dec.aluinb = 1'b1;
                dec.rwd    = 2'b01;
            end
            5'b00001: dec.jp = 1'b1;
            5'b00011: begin
                dec.jp  = 1'b1;
                dec.jal = 1'b1;
                dec.rwe = 1'b1;
            end
            5'b00010, 5'b00110: begin
                dec.br    = 1'b1;
                dec.aluop = ALUW'(1);
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // ctrl_d holds the outputs for the state being entered, so every output is a flop
    always_comb begin
        state_d  = state_q;
        ctrl_d   = '0;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        md_div_d = md_div_q;
        md_exc_d = md_exc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    if (dec_md) begin
                        state_d         = S_MD_WAIT;
                        cnt_d           = '0;
                        md_div_d        = dec_div;
                        md_exc_d        = 1'b0;
                        ctrl_d.md_start = 1'b1;
                        ctrl_d.md_op    = dec_div;
                    end else begin
                        state_d = S_EXEC;
                        ctrl_d  = dec;
                        pend_d  = dec_exc;
                    end
                end
            end
            S_EXEC: begin
                if (bus.alu_ovf && pend_q != 3'd0) begin
                    state_d = S_EXC;
                    ctrl_d  = exc_ctrl(pend_q);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MD_WAIT: begin
                cnt_d        = cnt_q + 1'b1;
                ctrl_d.md_op = md_div_q;
                if (bus.md_ready) begin
                    state_d           = S_MD_DONE;
                    md_exc_d          = bus.md_exc;
                    ctrl_d.ctrl_valid = 1'b1;
                    ctrl_d.rwe        = 1'b1;
                    ctrl_d.rdst       = 1'b1;
                    ctrl_d.rwd        = 2'b10;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_EXC;
                    ctrl_d  = exc_ctrl(3'd6);
                end
            end
            S_MD_DONE: begin
                if (md_exc_q) begin
                    state_d = S_EXC;
                    ctrl_d  = exc_ctrl(md_div_q ? 3'd5 : 3'd4);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            cnt_q    <= '0;
            pend_q   <= 3'd0;
            md_div_q <= 1'b0;
            md_exc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            md_div_q <= md_div_d;
            md_exc_q <= md_exc_d;
        end
    end

    assign bus.instr_ready = reset && (state_q == S_IDLE);
    assign bus.ctrl_valid  = ctrl_q.ctrl_valid;
    assign bus.br          = ctrl_q.br;
    assign bus.jp          = ctrl_q.jp;
    assign bus.jal         = ctrl_q.jal;
    assign bus.dmwe        = ctrl_q.dmwe;
    assign bus.rwe         = ctrl_q.rwe;
    assign bus.rdst        = ctrl_q.rdst;
    assign bus.aluinb      = ctrl_q.aluinb;
    assign bus.rwd         = ctrl_q.rwd;
    assign bus.aluop       = ctrl_q.aluop;
    assign bus.md_start    = ctrl_q.md_start;
    assign bus.md_op       = ctrl_q.md_op;
    assign bus.exc_rd      = ctrl_q.exc_rd;
    assign bus.exc_code    = ctrl_q.exc_code;
    assign bus.illegal     = ctrl_q.illegal;
endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: decode table, hand-built multi-cycle corner cases, async
// reset abort, and random instructions against a per-cycle timeline model.
module tb_ctrl_seq;
    localparam int T = 8;

    typedef struct packed {
        logic       ctrl_valid;
        logic       br;
        logic       jp;
        logic       jal;
        logic       dmwe;
        logic       rwe;
        logic       rdst;
        logic       aluinb;
        logic [1:0] rwd;
        logic [4:0] aluop;
        logic       md_start;
        logic       md_op;
        logic [4:0] exc_rd;
        logic [2:0] exc_code;
        logic       illegal;
    } obs_t;

    typedef struct {
        logic [4:0] opc;
        logic [4:0] alu;
        logic       ovf;
        obs_t       exp;
        logic [2:0] excc;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;
    obs_t exp_q[$];
    vec_t tbl[$];

    ctrl_seq_if #(.ALUW(5)) bus ();

    ctrl_seq #(.ALUW(5), .RSTAT(30), .MD_TIMEOUT(T), .CNTW(4)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic obs_t get_obs();
        obs_t o;
        o.ctrl_valid = bus.ctrl_valid;
        o.br         = bus.br;
        o.jp         = bus.jp;
        o.jal        = bus.jal;
        o.dmwe       = bus.dmwe;
        o.rwe        = bus.rwe;
        o.rdst       = bus.rdst;
        o.aluinb     = bus.aluinb;
        o.rwd        = bus.rwd;
        o.aluop      = bus.aluop;
        o.md_start   = bus.md_start;
        o.md_op      = bus.md_op;
        o.exc_rd     = bus.exc_rd;
        o.exc_code   = bus.exc_code;
        o.illegal    = bus.illegal;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic obs_t mk(input logic br, jp, jal, dmwe, rwe, rdst, aluinb,
                                input logic [1:0] rwd, input logic [4:0] aluop,
                                input logic ill);
        obs_t o = '0;
        o.ctrl_valid = 1'b1;
        o.br = br; o.jp = jp; o.jal = jal; o.dmwe = dmwe; o.rwe = rwe;
        o.rdst = rdst; o.aluinb = aluinb; o.rwd = rwd; o.aluop = aluop;
        o.illegal = ill;
        return o;
    endfunction

    function automatic obs_t exc_obs(input logic [2:0] code);
        obs_t o = '0;
        o.ctrl_valid = 1'b1;
        o.rwe        = 1'b1;
        o.rwd        = 2'b11;
        o.exc_rd     = 5'd30;
        o.exc_code   = code;
        return o;
    endfunction

    // Reference: decode straight from the opcode table; code is the overflow exception code
    task automatic ref_decode(input logic [4:0] opc, input logic [4:0] alu, output obs_t o,
                              output logic [2:0] code, output bit md, output bit dv);
        o = '0; o.ctrl_valid = 1'b1; code = 0; md = 0; dv = 0;
        if (opc == 5'b00000 && (alu == 5'd6 || alu == 5'd7)) begin
            md = 1; dv = (alu == 5'd7);
        end else if (opc == 5'b00000) begin
            o.rwe = 1; o.rdst = 1; o.aluop = alu;
            code = (alu == 5'd0) ? 3'd1 : (alu == 5'd1) ? 3'd3 : 3'd0;
        end else if (opc == 5'b00101) begin
            o.rwe = 1; o.aluinb = 1; code = 3'd2;
        end else if (opc == 5'b00111) begin
            o.dmwe = 1; o.aluinb = 1;
        end else if (opc == 5'b01000) begin
            o.rwe = 1; o.aluinb = 1; o.rwd = 2'b01;
        end else if (opc == 5'b00001) begin
            o.jp = 1;
        end else if (opc == 5'b00011) begin
            o.jp = 1; o.jal = 1; o.rwe = 1;
        end else if (opc == 5'b00010 || opc == 5'b00110) begin
            o.br = 1; o.aluop = 5'd1;
        end else begin
            o.illegal = 1;
        end
    endtask

    // Expected outputs for cycles N+1 .. N+L after acceptance at edge N; mdk = md_ready
    // cycle offset (0 = never asserted in the wait window)
    task automatic build_exp(input logic [4:0] opc, input logic [4:0] alu, input logic ovf,
                             input int mdk, input logic mdx);
        obs_t o; logic [2:0] code; bit md, dv; int w;
        ref_decode(opc, alu, o, code, md, dv);
        exp_q.delete();
        if (!md) begin
            exp_q.push_back(o);
            if (ovf && code != 0) exp_q.push_back(exc_obs(code));
        end else begin
            w = (mdk >= 1 && mdk <= T) ? mdk : T;
            for (int j = 1; j <= w; j++) begin
                o = '0; o.md_op = dv; o.md_start = (j == 1);
                exp_q.push_back(o);
            end
            if (mdk >= 1 && mdk <= T) begin
                o = '0; o.ctrl_valid = 1; o.rwe = 1; o.rdst = 1; o.rwd = 2'b10; o.md_op = dv;
                exp_q.push_back(o);
                if (mdx) exp_q.push_back(exc_obs(dv ? 3'd5 : 3'd4));
            end else begin
                exp_q.push_back(exc_obs(3'd6));
            end
        end
    endtask

    // Called at a negedge in IDLE; issues one instruction and checks every cycle
    // against exp_q, driving junk on inputs the sequencer must ignore.
    task automatic run_seq(input logic [4:0] opc, input logic [4:0] alu, input logic ovf,
                           input int mdk, input logic mdx, input string tag);
        int L, wend;
        L    = exp_q.size();
        wend = (mdk >= 1 && mdk <= T) ? mdk : T;
        chk({tag, "_ready"}, 64'(bus.instr_ready), 64'd1);
        chk({tag, "_idle"}, 64'(get_obs()), 64'd0);
        bus.instr_valid = 1'b1;
        bus.opcode      = opc;
        bus.alu_op_in   = alu;
        bus.alu_ovf     = 1'($urandom_range(1, 0));
        bus.md_ready    = 1'($urandom_range(1, 0));
        bus.md_exc      = 1'($urandom_range(1, 0));
        @(negedge clock);
        for (int j = 1; j <= L; j++) begin
            chk($sformatf("%s_c%0d", tag, j), 64'(get_obs()), 64'(exp_q[j-1]));
            chk($sformatf("%s_busy%0d", tag, j), 64'(bus.instr_ready), 64'd0);
            bus.instr_valid = (j == L) ? 1'b0 : 1'($urandom_range(1, 0));
            bus.opcode      = 5'($urandom);
            bus.alu_op_in   = 5'($urandom);
            bus.alu_ovf     = (j == 1) ? ovf : 1'($urandom_range(1, 0));
            if (mdk >= 0 && j <= wend) bus.md_ready = (j == mdk);
            else                       bus.md_ready = 1'($urandom_range(1, 0));
            bus.md_exc = (j == mdk) ? mdx : 1'($urandom_range(1, 0));
            @(negedge clock);
        end
    endtask

    initial begin
        logic [4:0] opcs [9];
        logic [4:0] opc, alu;
        logic       ovf, mdx;
        int         mdk;

        tbl.push_back('{5'b00101, 5'd0, 1'b0, mk(0,0,0,0,1,0,1,2'd0,5'd0,0), 3'd0});
        tbl.push_back('{5'b00101, 5'd9, 1'b1, mk(0,0,0,0,1,0,1,2'd0,5'd0,0), 3'd2});
        tbl.push_back('{5'b00000, 5'd0, 1'b1, mk(0,0,0,0,1,1,0,2'd0,5'd0,0), 3'd1});
        tbl.push_back('{5'b00000, 5'd1, 1'b1, mk(0,0,0,0,1,1,0,2'd0,5'd1,0), 3'd3});
        tbl.push_back('{5'b00000, 5'd2, 1'b1, mk(0,0,0,0,1,1,0,2'd0,5'd2,0), 3'd0});
        tbl.push_back('{5'b00000, 5'd0, 1'b0, mk(0,0,0,0,1,1,0,2'd0,5'd0,0), 3'd0});
        tbl.push_back('{5'b00111, 5'd3, 1'b1, mk(0,0,0,1,0,0,1,2'd0,5'd0,0), 3'd0});
        tbl.push_back('{5'b01000, 5'd0, 1'b0, mk(0,0,0,0,1,0,1,2'd1,5'd0,0), 3'd0});
        tbl.push_back('{5'b00001, 5'd0, 1'b0, mk(0,1,0,0,0,0,0,2'd0,5'd0,0), 3'd0});
        tbl.push_back('{5'b00011, 5'd0, 1'b0, mk(0,1,1,0,1,0,0,2'd0,5'd0,0), 3'd0});
        tbl.push_back('{5'b00010, 5'd0, 1'b1, mk(1,0,0,0,0,0,0,2'd0,5'd1,0), 3'd0});
        tbl.push_back('{5'b00110, 5'd4, 1'b0, mk(1,0,0,0,0,0,0,2'd0,5'd1,0), 3'd0});
        tbl.push_back('{5'b11111, 5'd0, 1'b1, mk(0,0,0,0,0,0,0,2'd0,5'd0,1), 3'd0});
        tbl.push_back('{5'b00100, 5'd0, 1'b0, mk(0,0,0,0,0,0,0,2'd0,5'd0,1), 3'd0});

        bus.instr_valid = 1'b0; bus.opcode = '0; bus.alu_op_in = '0;
        bus.alu_ovf = 1'b0; bus.md_ready = 1'b0; bus.md_exc = 1'b0;
        bus.instr_valid = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_ready", 64'(bus.instr_ready), 64'd0);
        chk("rst_outs", 64'(get_obs()), 64'd0);
        bus.instr_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rel_ready", 64'(bus.instr_ready), 64'd1);

        foreach (tbl[i]) begin
            exp_q.delete();
            exp_q.push_back(tbl[i].exp);
            if (tbl[i].excc != 0) exp_q.push_back(exc_obs(tbl[i].excc));
            run_seq(tbl[i].opc, tbl[i].alu, tbl[i].ovf, -1, 1'b0, $sformatf("tbl%0d", i));
        end

        build_exp(5'b00000, 5'd7, 1'b0, 5, 1'b1);
        run_seq(5'b00000, 5'd7, 1'b0, 5, 1'b1, "div_exc");
        build_exp(5'b00000, 5'd6, 1'b0, 0, 1'b0);
        run_seq(5'b00000, 5'd6, 1'b0, 0, 1'b0, "mul_tmo");
        build_exp(5'b00000, 5'd6, 1'b0, T, 1'b0);
        run_seq(5'b00000, 5'd6, 1'b0, T, 1'b0, "mul_edge");
        build_exp(5'b00000, 5'd6, 1'b0, 1, 1'b1);
        run_seq(5'b00000, 5'd6, 1'b0, 1, 1'b1, "mul_fast");

        // Async reset in the middle of a mul wait
        bus.instr_valid = 1'b1; bus.opcode = 5'b00000; bus.alu_op_in = 5'd6; bus.md_ready = 1'b0;
        @(negedge clock);
        chk("abort_start", 64'(bus.md_start), 64'd1);
        bus.instr_valid = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("abort_outs", 64'(get_obs()), 64'd0);
        chk("abort_ready", 64'(bus.instr_ready), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        bus.md_ready = 1'b1;
        bus.md_exc   = 1'b1;
        #1;
        chk("abort_rel_ready", 64'(bus.instr_ready), 64'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk($sformatf("abort_quiet%0d", c), 64'(get_obs()), 64'd0);
        end
        bus.md_ready = 1'b0;

        opcs = '{5'b00000, 5'b00000, 5'b00001, 5'b00010, 5'b00011,
                 5'b00101, 5'b00110, 5'b00111, 5'b01000};
        for (int n = 0; n < 80; n++) begin
            opc = ($urandom_range(7, 0) == 0) ? 5'($urandom) : opcs[$urandom_range(8, 0)];
            alu = 5'($urandom_range(7, 0));
            ovf = 1'($urandom_range(1, 0));
            mdk = $urandom_range(T, 0);
            mdx = 1'($urandom_range(1, 0));
            build_exp(opc, alu, ovf, mdk, mdx);
            run_seq(opc, alu, ovf, mdk, mdx, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Multi-cycle instruction control sequencer for the single-issue processor. It replaces the purely combinational opcode decoder. It accepts one instruction per handshake and presents registered control signals for exactly one cycle. It also stalls for the mult/div unit, with a timeout, and inserts an extra status-register write cycle on arithmetic exceptions. It sits between fetch/decode and the datapath muxes, ALU, data memory and mult/div unit.

## Interface
Parameters:
- ALUW, 5, ALU op field width.
- RSTAT, 30, register index written on exception.
- MD_TIMEOUT, 64, max cycles to wait for `md_ready` (≥2).
- CNTW, 7, width of the timeout counter. Must satisfy 2^CNTW > MD_TIMEOUT.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction fields valid.
- instr_ready  out  1  high only in IDLE while reset is deasserted.
- opcode  in  5  instruction opcode.
- alu_op_in  in  ALUW  R-type ALU op field.
- alu_ovf  in  1  ALU overflow, sampled in EXEC.
- md_ready  in  1  mult/div result ready.
- md_exc  in  1  mult/div exception, qualified by md_ready.
- ctrl_valid  out  1  control outputs valid this cycle.
- br, jp, jal, dmwe, rwe, rdst, aluinb  out  1 each  datapath controls.
- rwd  out  2  writeback select: 00 ALU, 01 memory, 10 mult/div, 11 exception code.
- aluop  out  ALUW  ALU operation.
- md_start  out  1  one-cycle start pulse to mult/div.
- md_op  out  1  0 = mul, 1 = div; held from start until completion.
- exc_rd  out  5  destination register override; equals RSTAT during EXC, else 0.
- exc_code  out  3  exception code, valid when rwd = 11.
- illegal  out  1  one-cycle pulse for an unknown opcode.

## Operation
- States are IDLE, EXEC, MD_WAIT, MD_DONE and EXC.
- An instruction is accepted when instr_valid & instr_ready are both high at a clock edge. The decoded controls are latched into output registers at that edge.
- Decode, for every field not listed the value is 0:
  - 00000 R-type: rwe, rdst, aluop = alu_op_in.
  - R-type with alu_op_in = 00110 (mul) or 00111 (div): goes to the mult/div path instead.
  - 00101 addi: rwe, aluinb.
  - 00111 sw: dmwe, aluinb.
  - 01000 lw: rwe, aluinb, rwd = 01.
  - 00001 j: jp.
  - 00011 jal: jp, jal, rwe.
  - 00010 bne and 00110 blt: br, aluop = 00001.
  - Any other opcode: all controls 0, illegal = 1 together with ctrl_valid.
- IDLE→EXEC on accepting a non-mult/div instruction. EXEC drives ctrl_valid = 1 for one cycle.
- EXEC→EXC when alu_ovf = 1 and the op is add (code 1), addi (code 2) or sub (code 3). Otherwise EXEC→IDLE.
- EXC: ctrl_valid = 1, rwe = 1, rwd = 11, exc_rd = RSTAT, exc_code set. EXC→IDLE.
- IDLE→MD_WAIT on accepting mul/div. md_start pulses during the first MD_WAIT cycle and the counter loads 0.
- MD_WAIT: the counter increments every cycle.
  - md_ready → MD_DONE.
  - Counter reaching MD_TIMEOUT−1 without md_ready → EXC with code 6.
- MD_DONE: ctrl_valid = 1, rwe = 1, rdst = 1, rwd = 10.
  - If md_exc was captured with md_ready, go to EXC with code 4 (mul) or 5 (div).
  - Otherwise go to IDLE.
- md_ready while not in MD_WAIT is ignored.
- All outputs are registered except instr_ready.

## Timing
- Reset values: every output 0, state IDLE, counter 0. instr_ready is 0 while reset is asserted and 1 in the first cycle after release.
- Reset is asynchronous from any state, including MD_WAIT and EXC. The in-flight instruction is discarded and no ctrl_valid is issued for it.
- Single-cycle ops: ctrl_valid is high in cycle N+1 after acceptance at edge N. The next acceptance is possible at edge N+2, so throughput is 1 instruction per 2 cycles.
- Overflow adds one cycle: EXC occupies N+2 and acceptance is possible at edge N+3.
- Mult/div: md_start is high in N+1. If md_ready is high in cycle N+k, ctrl_valid is high in N+k+1.
- Timeout: if md_ready is never seen, EXC falls in cycle N+MD_TIMEOUT+1.
- md_ready arriving in the same cycle as the timeout boundary wins; the result is written, not the timeout.
- instr_valid is ignored while instr_ready is low. The opcode is not required to be held after acceptance.

## Test plan
- Reset release, then addi (00101): ctrl_valid pulses one cycle with rwe = 1, aluinb = 1, aluop = 0, all else 0. instr_ready drops for exactly 1 cycle.
- R-type add (alu_op_in = 00000) with alu_ovf = 1 in EXEC: the EXEC cycle is followed by an EXC cycle with rwe = 1, rwd = 11, exc_rd = 30, exc_code = 1. The next accept is 3 cycles after the first.
- div with md_ready after 5 cycles and md_exc = 1: md_start pulses once and md_op = 1. MD_DONE has rwd = 10. EXC follows with exc_code = 5.
- mul with md_ready never asserted and MD_TIMEOUT = 8: EXC with exc_code = 6 occurs 9 cycles after acceptance. md_ready asserted exactly at the boundary instead gives MD_DONE.
- Opcode 11111: illegal and ctrl_valid are both high for one cycle with all controls 0.
- Reset asserted mid MD_WAIT: all outputs are 0 immediately, without waiting for a clock edge. After release, no ctrl_valid appears for the aborted op and instr_ready = 1.
